output_collector: RTL and testbench
===================================

OUTPUT_COLLECTOR -- requirements
Module: output_collector

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32: width of the incoming accumulator value.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: width of the emitted signed result.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: buffer entries; must be a power of two and at least 2.
REQ-004 SHALL have parameters FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT and OUTPUT_NB_CHANNELS, defaults 1024, 1024 and 64: these define the expected output count TOTAL = W*H*C.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port arst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port start, input, 1 bit: begins a collection run.
REQ-008 Ports in_valid (1 bit), in_data (ACC_WIDTH), in_x, in_y and in_ch (32 bits each), all inputs: a result from the conv controller/datapath; there is no ready signal because the producer cannot stall.
REQ-009 Ports out_valid (output, 1), out_ready (input, 1), out_data (output, OUT_WIDTH), and out_x, out_y, out_ch (outputs, 32 each): the downstream valid/ready stream.
REQ-010 Port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: the current number of buffered entries.
REQ-011 Ports busy, done and overflow, outputs, 1 bit each: status flags.

Function
REQ-012 SHALL implement an FSM with states IDLE, ACTIVE and DONE.
REQ-013 FSM transitions: IDLE->ACTIVE on start; ACTIVE->DONE in the cycle after the popped count reaches TOTAL; DONE->ACTIVE on start.
REQ-014 Entering ACTIVE SHALL clear the pushed count, the popped count and overflow; FIFO contents are already empty at that point.
REQ-015 busy SHALL be 1 exactly in ACTIVE; done SHALL be 1 exactly in DONE.
REQ-016 start asserted in ACTIVE SHALL be ignored.
REQ-017 Push: in ACTIVE, in_valid=1 and (not full or a pop in the same cycle) SHALL store {converted data, x, y, ch}.
REQ-018 Push when full with no pop SHALL drop the entry and set overflow; overflow is sticky until the next run starts or reset.
REQ-019 in_valid outside ACTIVE SHALL be ignored, with no overflow.
REQ-020 Conversion: in_data SHALL be treated as signed and saturated to the signed OUT_WIDTH range; e.g. 40000 -> 32767, -40000 -> -32768.
REQ-021 Latency: an entry pushed in cycle N SHALL present out_valid=1 in cycle N+1 at the earliest; the path is registered, with no fall-through.
REQ-022 Pop occurs when out_valid && out_ready.
REQ-023 out_valid, out_data and the coordinate outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged, including at full and at empty+1.
REQ-025 Order SHALL be strictly FIFO; read and write pointers wrap modulo FIFO_DEPTH.
REQ-026 Counts SHALL be 32 bits; dropped entries are not counted as pushed.

Reset
REQ-027 While arst_n_in=0, the block SHALL be in state IDLE with fifo_level=0, out_valid=0, out_data/out_x/out_y/out_ch=0, busy=0, done=0, overflow=0 and counts=0.
REQ-028 Reset asserted mid-run SHALL discard all buffered entries immediately; after release the block waits in IDLE for start.

Configuration
REQ-029 Macro OUTPUT_COLLECTOR_RELU_EN: when defined, negative converted values SHALL be emitted as 0 (e.g. -5 -> 0, -40000 -> 0); when undefined, values are emitted as saturated signed results only.

Structure
REQ-030 A shared package conv_pkg SHALL hold the collector_state_t enum (IDLE, ACTIVE, DONE) and the constant COORD_WIDTH=32.
REQ-031 Buffering SHALL be a sub-module sync_fifo, parameterised by width and depth, with a registered output and a level output; output_collector holds the FSM, conversion, counters and flags.

Verification
REQ-032 Run W=H=C=2 (TOTAL=8), start, 8 single pushes with out_ready=1 -> 8 pops in order; done=1 one cycle after the 8th pop; overflow=0.
REQ-033 Hold out_ready=0, push 8 with FIFO_DEPTH=8 -> fifo_level=8, overflow=0; a 9th push -> dropped, overflow=1; after draining, the data seen is entries 1..8.
REQ-034 Full FIFO, out_ready=1 plus a push in the same cycle -> fifo_level stays 8, no overflow, and the new entry is emitted last.
REQ-035 in_data = 70000, -70000 and -3 -> out_data = 32767, -32768 and -3; with OUTPUT_COLLECTOR_RELU_EN defined -> 32767, 0 and 0.
REQ-036 Assert arst_n_in low with 5 entries buffered -> out_valid=0, fifo_level=0, IDLE; in_valid before start -> ignored; start -> run completes normally.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution output path.
package conv_pkg;

  localparam int COORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } collector_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output and an occupancy level.
// A write becomes visible on rdata/rvalid one cycle later; there is no fall-through.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      level_next;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop && rvalid;
  assign push_ok = push && (!full || pop_ok);
  assign rd_next = rd_ptr + AW'(pop_ok);

  always_comb begin
    level_next = level;
    if (push_ok && !pop_ok) begin
      level_next = level + (AW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      level_next = level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // The head register is fed from the incoming word when it lands in the slot
  // that becomes the new head, since mem does not hold it until this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;
      level  <= level_next;
      rvalid <= (level_next != '0);
      if (level_next == '0) begin
        rdata <= '0;
      end else if (push_ok && (wr_ptr == rd_next)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/output_collector.sv
// Collects conv results into a FIFO, saturates them to OUT_WIDTH and streams them out.
// Optional macro OUTPUT_COLLECTOR_RELU_EN clamps negative results to zero.
module output_collector
  import conv_pkg::*;
#(
  parameter int ACC_WIDTH          = 32,
  parameter int OUT_WIDTH          = 16,
  parameter int FIFO_DEPTH         = 8,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [ACC_WIDTH-1:0]          in_data,
  input  logic [COORD_WIDTH-1:0]        in_x,
  input  logic [COORD_WIDTH-1:0]        in_y,
  input  logic [COORD_WIDTH-1:0]        in_ch,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [COORD_WIDTH-1:0]        out_x,
  output logic [COORD_WIDTH-1:0]        out_y,
  output logic [COORD_WIDTH-1:0]        out_ch,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int          FW    = OUT_WIDTH + 3 * COORD_WIDTH;
  localparam logic [31:0] TOTAL = 32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

`ifdef OUTPUT_COLLECTOR_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  collector_state_t     state;
  logic [31:0]          pushed_cnt;
  logic [31:0]          popped_cnt;
  logic [OUT_WIDTH-1:0] conv_data;
  logic [FW-1:0]        fifo_rdata;
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 pop;
  logic                 accept;

  assign pop       = out_valid && out_ready;
  assign fifo_push = (state == ACTIVE) && in_valid;
  assign accept    = fifo_push && (!fifo_full || pop);

  always_comb begin
    conv_data = in_data[OUT_WIDTH-1:0];
    if ($signed(in_data) > SAT_MAX) begin
      conv_data = SAT_MAX[OUT_WIDTH-1:0];
    end else if ($signed(in_data) < SAT_MIN) begin
      conv_data = SAT_MIN[OUT_WIDTH-1:0];
    end
    if (RELU && conv_data[OUT_WIDTH-1]) begin
      conv_data = '0;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (arst_n_in),
    .push   (fifo_push),
    .wdata  ({conv_data, in_x, in_y, in_ch}),
    .pop    (out_ready),
    .rdata  (fifo_rdata),
    .rvalid (out_valid),
    .level  (fifo_level),
    .full   (fifo_full)
  );

  assign {out_data, out_x, out_y, out_ch} = fifo_rdata;

  // Run control; a start landing in ACTIVE falls through to the ACTIVE arm and is ignored.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      pushed_cnt <= '0;
      popped_cnt <= '0;
    end else begin
      if (pop) begin
        popped_cnt <= popped_cnt + 32'd1;
      end
      if (accept) begin
        pushed_cnt <= pushed_cnt + 32'd1;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= ACTIVE;
            busy       <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            pushed_cnt <= '0;
            popped_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (fifo_push && fifo_full && !pop) begin
            overflow <= 1'b1;
          end
          if ((popped_cnt + 32'(pop)) == TOTAL) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_collector.sv
// Self-checking bench for output_collector: queue-based reference model plus directed literal checks.
module tb_output_collector;

  localparam int DEPTH = 8;
  localparam int TOTAL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] in_x = '0;
  logic [31:0] in_y = '0;
  logic [31:0] in_ch = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [31:0] out_ch;
  logic [3:0]  fifo_level;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  output_collector #(
    .ACC_WIDTH          (32),
    .OUT_WIDTH          (16),
    .FIFO_DEPTH         (DEPTH),
    .FEATURE_MAP_WIDTH  (2),
    .FEATURE_MAP_HEIGHT (2),
    .OUTPUT_NB_CHANNELS (2)
  ) dut (
    .clk        (clk),
    .arst_n_in  (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_ch      (in_ch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_ch     (out_ch),
    .fifo_level (fifo_level),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] expect_conv(input logic [31:0] raw);
    longint v;
    v = longint'($signed(raw));
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`ifdef OUTPUT_COLLECTOR_RELU_EN
    if (v < 0) v = 0;
`endif
    return v[15:0];
  endfunction

  // Reference model: a queue of pending results plus run status.
  typedef struct {
    logic [15:0] d;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
  } entry_t;
  typedef enum {M_IDLE, M_ACTIVE, M_DONE} mstate_t;

  entry_t  q[$];
  mstate_t m_state = M_IDLE;
  int      m_popped = 0;
  bit      m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit     pop_now;
    bit     full_now;
    entry_t e;
    if (!rst_n) begin
      q.delete();
      m_state  = M_IDLE;
      m_popped = 0;
      m_ovf    = 1'b0;
    end else begin
      pop_now  = (q.size() > 0) && out_ready;
      full_now = (q.size() == DEPTH);
      if (pop_now) begin
        void'(q.pop_front());
        m_popped++;
      end
      if (m_state == M_ACTIVE && in_valid) begin
        if (!full_now || pop_now) begin
          e.d  = expect_conv(in_data);
          e.x  = in_x;
          e.y  = in_y;
          e.ch = in_ch;
          q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      case (m_state)
        M_IDLE, M_DONE: if (start) begin
          m_state  = M_ACTIVE;
          m_popped = 0;
          m_ovf    = 1'b0;
        end
        M_ACTIVE: if (m_popped == TOTAL) m_state = M_DONE;
        default: m_state = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_x", out_x, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overflow", overflow, 0);
    end else begin
      check("out_valid", out_valid, (q.size() != 0));
      check("fifo_level", fifo_level, q.size());
      check("busy", busy, (m_state == M_ACTIVE));
      check("done", done, (m_state == M_DONE));
      check("overflow", overflow, m_ovf);
      if (q.size() != 0) begin
        check("out_data", out_data, q[0].d);
        check("out_x", out_x, q[0].x);
        check("out_y", out_y, q[0].y);
        check("out_ch", out_ch, q[0].ch);
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] d, input bit rdy, input bit st);
    in_valid  = v;
    in_data   = d;
    in_x      = $urandom;
    in_y      = $urandom;
    in_ch     = $urandom;
    out_ready = rdy;
    start     = st;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 2))
      0:       return 32'($urandom_range(0, 200)) - 32'd100;
      1:       return $urandom;
      default: return 32'd32766 + 32'($urandom_range(0, 3)) - (($urandom_range(0, 1) != 0) ? 32'd65535 : 32'd0);
    endcase
  endfunction

  task automatic random_run(input string name);
    bit finished;
    finished = 1'b0;
    step(0, 0, 1, 1);
    for (int k = 0; k < 400 && !finished; k++) begin
      step($urandom_range(0, 1) != 0, rand_data(), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      if (done) finished = 1'b1;
    end
    check({name, "_completes"}, finished, 1);
    for (int k = 0; k < 20 && out_valid; k++) step(0, 0, 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq3[8];
    int sat_in[3];
    int sat_exp[3];

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_level_lit", fifo_level, 0);
    check("reset_busy_lit", busy, 0);
    rst_n = 1'b1;
    step(0, 0, 1, 0);
    check("idle_done_lit", done, 0);

    // Basic run: eight single pushes streamed straight out.
    step(0, 0, 1, 1);
    check("run1_busy_lit", busy, 1);
    for (int i = 0; i < 8; i++) step(1, 32'(i * 10000 - 35000), 1, 0);
    check("run1_done_before_lit", done, 0);
    step(0, 0, 1, 0);
    check("run1_done_lit", done, 1);
    check("run1_ovf_lit", overflow, 0);

    // Fill to full, overflow on the ninth, drain in order.
    step(0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) step(1, 32'(i), 0, 0);
    check("run2_level_full_lit", fifo_level, 8);
    check("run2_ovf_clear_lit", overflow, 0);
    step(1, 32'd9, 0, 0);
    check("run2_level_still_full_lit", fifo_level, 8);
    check("run2_ovf_set_lit", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      check("run2_drain_valid_lit", out_valid, 1);
      check("run2_drain_data_lit", out_data, i);
      step(0, 0, 1, 0);
    end
    check("run2_empty_lit", fifo_level, 0);
    check("run2_done_lit", done, 1);

    // Full FIFO with push and pop in the same cycle.
    step(0, 0, 0, 1);
    for (int i = 11; i <= 18; i++) step(1, 32'(i), 0, 0);
    check("run3_level_full_lit", fifo_level, 8);
    step(1, 32'd99, 1, 0);
    check("run3_level_kept_lit", fifo_level, 8);
    check("run3_ovf_lit", overflow, 0);
    seq3 = '{12, 13, 14, 15, 16, 17, 18, 99};
    for (int i = 0; i < 8; i++) begin
      check("run3_order_lit", out_data, seq3[i]);
      step(0, 0, 1, 0);
    end
    check("run3_empty_lit", fifo_level, 0);

    // Saturation and optional clamp.
    sat_in = '{70000, -70000, -3};
`ifdef OUTPUT_COLLECTOR_RELU_EN
    sat_exp = '{32767, 0, 0};
`else
    sat_exp = '{32767, -32768, -3};
`endif
    step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'(sat_in[i]), 1, 0);
      check("sat_valid_lit", out_valid, 1);
      check("sat_value_lit", longint'($signed(out_data)), sat_exp[i]);
    end
    for (int i = 0; i < 5; i++) step(1, rand_data(), 1, 0);
    step(0, 0, 1, 0);
    check("sat_run_done_lit", done, 1);

    // Reset mid-run with five entries buffered.
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, rand_data(), 0, 0);
    check("mid_level_lit", fifo_level, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid_lit", out_valid, 0);
    check("mid_rst_level_lit", fifo_level, 0);
    check("mid_rst_busy_lit", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 32'd123, 1, 0);
    check("pre_start_level_lit", fifo_level, 0);
    check("pre_start_valid_lit", out_valid, 0);
    check("pre_start_ovf_lit", overflow, 0);
    check("pre_start_busy_lit", busy, 0);
    random_run("post_reset_run");

    for (int r = 0; r < 4; r++) random_run("random_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
